fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the core control unit. Holds the program counter and computes the next PC from the control unit's pc_sel. Selects the executed instruction word from memory read data, a held copy, or an injected NOP according to inst_sel. Splits that word into the opcode/func3/func7/register fields consumed by the control unit, register file and immediate mux.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, next-PC select, instruction mux, field split
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel,
    input  logic [1:0]  inst_sel,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_p4,
    output logic [31:0] inst,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        inst_illegal,
    output logic        misaligned,
    output logic [31:0] instret
);

    localparam logic [1:0] PC_P4    = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_OLD   = 2'd2;
    localparam logic [1:0] PC_M4    = 2'd3;

    localparam logic [1:0] INST_MEM = 2'd0;
    localparam logic [1:0] INST_NOP = 2'd1;
    localparam logic [1:0] INST_OLD = 2'd2;

    logic [31:0] inst_old;

    // Bit 0 of a jump target is discarded (JALR rule), so it is intentionally unused.
    logic unused_alu_bit0;
    assign unused_alu_bit0 = alu_out[0];

    assign pc_p4 = pc + 32'd4;

    // Program counter: next address chosen by the control unit, one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            case (pc_sel)
                PC_P4:   pc <= pc + 32'd4;
                PC_ALU:  pc <= {alu_out[31:2], 2'b00};
                PC_OLD:  pc <= pc;
                PC_M4:   pc <= pc - 32'd4;
                default: pc <= pc;
            endcase
        end
    end

    // Sticky flag: any jump target with bit 1 set marks the stream misaligned until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (pc_sel == PC_ALU && alu_out[1]) begin
            misaligned <= 1'b1;
        end
    end

    // Executed-word select; the reserved code falls back to a NOP.
    always_comb begin
        inst = NOP_WORD;
        case (inst_sel)
            INST_MEM: inst = mem_rdata;
            INST_NOP: inst = NOP_WORD;
            INST_OLD: inst = inst_old;
            default:  inst = NOP_WORD;
        endcase
    end

    // Hold last cycle's executed word so INST_OLD can replay it any number of times.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_old <= NOP_WORD;
        end else begin
            inst_old <= inst;
        end
    end

    // Retired-instruction counter: only words taken from memory count.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= 32'd0;
        end else if (inst_sel == INST_MEM) begin
            instret <= instret + 32'd1;
        end
    end

    assign opcode       = inst[6:2];
    assign func3        = inst[14:12];
    assign func7        = inst[31:25];
    assign rd           = inst[11:7];
    assign rs1          = inst[19:15];
    assign rs2          = inst[24:20];
    assign inst_illegal = (inst[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, load/replay sequence, random vs model
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel, inst_sel;
    logic [31:0] alu_out, mem_rdata;
    logic [31:0] pc, pc_p4, inst, instret;
    logic [4:0]  opcode, rd, rs1, rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        inst_illegal, misaligned;

    fetch_unit #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .inst_sel(inst_sel),
        .alu_out(alu_out), .mem_rdata(mem_rdata), .pc(pc), .pc_p4(pc_p4),
        .inst(inst), .opcode(opcode), .func3(func3), .func7(func7), .rd(rd),
        .rs1(rs1), .rs2(rs2), .inst_illegal(inst_illegal),
        .misaligned(misaligned), .instret(instret)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference state, described in architectural terms
    logic [31:0] m_pc, m_old, m_ir;
    logic        m_mis;
    bit          m_valid = 0;

    typedef struct {
        logic        r;
        logic [1:0]  ps;
        logic [1:0]  is;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] e_inst;
        logic [31:0] e_pc_p4;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_ir;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_inst(input logic [1:0] s, input logic [31:0] mem);
        if (s == 2'd0)      return mem;
        else if (s == 2'd2) return m_old;
        else                return NOP;
    endfunction

    // Drive inputs mid-cycle and check the combinational outputs against the model
    task automatic drive(input logic r, input logic [1:0] ps, input logic [1:0] is,
                         input logic [31:0] alu, input logic [31:0] mem);
        logic [31:0] e;
        @(negedge clk);
        rst = r; pc_sel = ps; inst_sel = is; alu_out = alu; mem_rdata = mem;
        #1;
        e = m_inst(is, mem);
        chk("inst", inst, e);
        chk("opcode", {27'd0, opcode}, {27'd0, e[6:2]});
        chk("func3", {29'd0, func3}, {29'd0, e[14:12]});
        chk("func7", {25'd0, func7}, {25'd0, e[31:25]});
        chk("rd", {27'd0, rd}, {27'd0, e[11:7]});
        chk("rs1", {27'd0, rs1}, {27'd0, e[19:15]});
        chk("rs2", {27'd0, rs2}, {27'd0, e[24:20]});
        chk("inst_illegal", {31'd0, inst_illegal}, {31'd0, (e[1:0] != 2'b11)});
        if (m_valid) begin
            chk("pc_pre", pc, m_pc);
            chk("pc_p4", pc_p4, m_pc + 32'd4);
        end
    endtask

    // Clock edge: advance the model and check registered state
    task automatic tick();
        logic [31:0] e;
        e = m_inst(inst_sel, mem_rdata);
        @(posedge clk);
        if (rst) begin
            m_pc = RPC; m_old = NOP; m_mis = 1'b0; m_ir = 32'd0;
        end else begin
            if (pc_sel == 2'd0)      m_pc = m_pc + 32'd4;
            else if (pc_sel == 2'd1) begin
                m_pc = alu_out & 32'hFFFF_FFFC;
                if (alu_out[1]) m_mis = 1'b1;
            end
            else if (pc_sel == 2'd3) m_pc = m_pc - 32'd4;
            m_old = e;
            if (inst_sel == 2'd0) m_ir = m_ir + 32'd1;
        end
        m_valid = 1;
        #1;
        chk("pc", pc, m_pc);
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
        chk("instret", instret, m_ir);
    endtask

    task automatic step(input logic r, input logic [1:0] ps, input logic [1:0] is,
                        input logic [31:0] alu, input logic [31:0] mem);
        drive(r, ps, is, alu, mem);
        tick();
    endtask

    logic [31:0] w;

    initial begin
        // Table: {rst, pc_sel, inst_sel, alu_out, mem_rdata, inst, pc_p4, pc_next, misaligned, instret}
        tbl[0]  = '{0, 2'd0, 2'd0, 32'h0,         32'h0050_0093, 32'h0050_0093, 32'h104, 32'h104, 0, 1};
        tbl[1]  = '{0, 2'd0, 2'd0, 32'h0,         32'h0050_0093, 32'h0050_0093, 32'h108, 32'h108, 0, 2};
        tbl[2]  = '{0, 2'd0, 2'd0, 32'h0,         32'h0050_0093, 32'h0050_0093, 32'h10C, 32'h10C, 0, 3};
        tbl[3]  = '{0, 2'd1, 2'd2, 32'h200,       32'hDEAD_BEEF, 32'h0050_0093, 32'h110, 32'h200, 0, 3};
        tbl[4]  = '{0, 2'd1, 2'd1, 32'h341,       32'hDEAD_BEEF, 32'h13,        32'h204, 32'h340, 0, 3};
        tbl[5]  = '{0, 2'd1, 2'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h13,        32'h344, 32'hFFFF_FFFC, 0, 3};
        tbl[6]  = '{0, 2'd0, 2'd1, 32'h0,         32'h0,         32'h13,        32'h0,   32'h0,   0, 3};
        tbl[7]  = '{0, 2'd3, 2'd1, 32'h0,         32'h0,         32'h13,        32'h4,   32'hFFFF_FFFC, 0, 3};
        tbl[8]  = '{0, 2'd1, 2'd1, 32'h102,       32'h0,         32'h13,        32'h0,   32'h100, 1, 3};
        tbl[9]  = '{0, 2'd1, 2'd1, 32'h200,       32'h0,         32'h13,        32'h104, 32'h200, 1, 3};
        tbl[10] = '{0, 2'd1, 2'd1, 32'h300,       32'h0,         32'h13,        32'h204, 32'h300, 1, 3};
        tbl[11] = '{0, 2'd1, 2'd1, 32'h400,       32'h0,         32'h13,        32'h304, 32'h400, 1, 3};
        tbl[12] = '{0, 2'd1, 2'd1, 32'h500,       32'h0,         32'h13,        32'h404, 32'h500, 1, 3};
        tbl[13] = '{0, 2'd1, 2'd1, 32'h600,       32'h0,         32'h13,        32'h504, 32'h600, 1, 3};
        tbl[14] = '{1, 2'd2, 2'd2, 32'h0,         32'h1234_5677, 32'h13,        32'h604, 32'h100, 0, 0};
        tbl[15] = '{0, 2'd0, 2'd2, 32'h0,         32'h1234_5677, 32'h13,        32'h104, 32'h104, 0, 0};

        rst = 1'b1; pc_sel = 2'd0; inst_sel = 2'd1; alu_out = '0; mem_rdata = '0;
        step(1'b1, 2'd0, 2'd1, 32'h0, 32'h0);
        step(1'b1, 2'd0, 2'd1, 32'h0, 32'h0);
        chk("reset pc", pc, RPC);
        chk("reset instret", instret, 32'd0);
        chk("reset misaligned", {31'd0, misaligned}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].ps, tbl[i].is, tbl[i].alu, tbl[i].mem);
            chk($sformatf("tbl%0d inst", i), inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d pc_p4", i), pc_p4, tbl[i].e_pc_p4);
            tick();
            chk($sformatf("tbl%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d mis", i), {31'd0, misaligned}, {31'd0, tbl[i].e_mis});
            chk($sformatf("tbl%0d instret", i), instret, tbl[i].e_ir);
        end

        // Load re-fetch: take a memory word at 0x40 while backing up, replay it, then flush
        step(1'b0, 2'd1, 2'd1, 32'h40, 32'h0);
        drive(1'b0, 2'd3, 2'd0, 32'h0, 32'h00A1_2083);
        w = inst;
        tick();
        chk("load pc back", pc, 32'h3C);
        chk("load instret", instret, 32'd1);
        drive(1'b0, 2'd0, 2'd2, 32'h0, 32'hFFFF_0000);
        chk("replay word", inst, 32'h00A1_2083);
        tick();
        chk("load pc fwd", pc, 32'h40);
        drive(1'b0, 2'd2, 2'd2, 32'h0, 32'h0);
        chk("replay again", inst, w);
        tick();
        step(1'b0, 2'd0, 2'd1, 32'h0, 32'h0);
        chk("load instret once", instret, 32'd1);
        chk("after flush pc", pc, 32'h44);

        // Illegal encoding straight from memory
        drive(1'b0, 2'd2, 2'd0, 32'h0, 32'h0000_0000);
        chk("illegal flag", {31'd0, inst_illegal}, 32'd1);
        tick();

        // Random stimulus against the model, occasional reset
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
